display_serializer: RTL
=======================

Name: display_serializer

Overview:
Parametrised serial 7-segment display driver for the calculator datapath.
- Takes NUM_DIGITS packed BCD digits plus per-digit decimal points, decodes them to segment patterns and shifts the whole frame out on a ser_clk/ser_data pair to the external shift-register display chain.
- Pulses latch at frame end, and exposes a start/busy/done handshake to the calculator control FSM.
- Generalises the fixed 4-digit, 32-bit output block with configurable digit count, bit clock divider, shift order and a minus-sign glyph.

Parameters:
- NUM_DIGITS, 4, number of displayed digits (≥1).
- SEG_BITS, 8, bits per digit frame {dp,g,f,e,d,c,b,a} (fixed at 8; present for package consistency).
- CLK_DIV, 4, system clocks per ser_clk half-period (≥1).
- MSB_FIRST, 1, 1: bit 7 (dp) of each digit shifted first; 0: bit 0 (a) first.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 clears on next rising clk).
- enable  in  1  gates acceptance of start.
- start  in  1  request a frame; sampled only in IDLE.
- bcd_in  in  4*NUM_DIGITS  packed digits; digit k at bits [4k+3:4k]; digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, active high.
- ser_clk  out  1  serial bit clock to display chain.
- ser_data  out  1  serial data; stable across ser_clk rising edge.
- latch  out  1  storage-register strobe, high CLK_DIV cycles at frame end.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE; ser_clk=0, ser_data=0, latch=0, busy=0, done=0; counters cleared. A reset during a frame aborts it immediately; no latch and no done.
- Decode (active-high segments):
  - BCD 0–9 → 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - 4'hA → minus (40).
  - 4'hB–4'hF → blank (00).
  - dp_in[k] ORs bit 7.
- FSM states: IDLE → SHIFT → LATCH → DONE → IDLE.
- IDLE:
  - If start && enable at edge T: snapshot the decoded frame (NUM_DIGITS*8 bits) into the shift register; go to SHIFT; busy=1 from T+1.
  - start with enable==0 is ignored.
- SHIFT:
  - Digit NUM_DIGITS-1 is sent first and digit 0 last. Within each digit, order follows MSB_FIRST.
  - Each bit occupies 2*CLK_DIV cycles: ser_clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - ser_data updates only on the cycle ser_clk goes low.
  - After the last bit's high phase, go to LATCH.
- LATCH: ser_clk=0, latch=1 for CLK_DIV cycles; ser_data holds its last value; then go to DONE.
- DONE: done=1 and busy=0 for one cycle; return to IDLE. A start in that cycle is ignored; the earliest new frame is the next IDLE cycle.
- Busy duration: 2*CLK_DIV*NUM_DIGITS*8 + CLK_DIV cycles (260 for defaults).
- Input and enable rules during a frame:
  - start while busy is ignored (no queueing).
  - bcd_in/dp_in changes have no effect on the current frame.
  - enable falling mid-frame does not abort; the frame completes.
- Counters: divider width $clog2(CLK_DIV)+1; bit counter width $clog2(NUM_DIGITS*8)+1. Neither counter may wrap.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: from digit NUM_DIGITS-1 downward, digits equal to 0 with dp_in==0 are sent as 00 until the first nonzero digit or a dp. Digit 0 is never blanked. A minus code (4'hA) stops blanking.
- Undefined: every digit is decoded verbatim.

Decomposition:
- Shared package display_pkg:
  - Segment constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK.
  - BCD_MINUS=4'hA.
  - State encoding localparams (S_IDLE, S_SHIFT, S_LATCH, S_DONE).
- One sub-module, bcd_to_7seg: combinational 4-bit BCD + dp → 8-bit pattern, instantiated NUM_DIGITS times via generate.

Test Plan:
- Defaults, bcd_in=16'h2571, dp_in=0, start pulse → 32 bits on ser_data at ser_clk rising edges = 5B 6D 07 06 (MSB first); latch high 4 cycles; done 1 cycle; busy exactly 260 cycles.
- bcd_in=16'hA009, dp_in=4'b0010, MSB_FIRST=0 → bytes 40,3F,BF,6F each sent LSB first.
- start held high through the whole frame and through DONE → exactly one frame and one done, then a second frame starting the first IDLE cycle after DONE.
- reset driven 0 at cycle 100 of a frame → next cycle all outputs 0, state IDLE, no latch or done; a fresh start afterwards yields a full correct frame.
- enable=0 with start pulse → no activity; enable dropped mid-frame → frame completes normally.
- LEADING_ZERO_BLANK_EN defined, bcd_in=16'h0070 → 00 00 07 3F; bcd_in=16'h0000 → 00 00 00 3F.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg -- shared definitions for the serial 7-segment display driver.
// Segment patterns are active high, bit order {dp,g,f,e,d,c,b,a}.
// Holds the glyph constants, the minus-sign BCD code and the FSM state type.
package display_pkg;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [3:0] BCD_MINUS = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg -- combinational BCD digit to 7-segment pattern decoder.
// Ports:
//   bcd  in  4  BCD code; 0-9 digits, 4'hA minus sign, 4'hB-4'hF blank
//   dp   in  1  decimal point, ORed into bit 7
//   seg  out 8  pattern {dp,g,f,e,d,c,b,a}, active high
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    case (bcd)
      4'd0:      glyph = SEG_0;
      4'd1:      glyph = SEG_1;
      4'd2:      glyph = SEG_2;
      4'd3:      glyph = SEG_3;
      4'd4:      glyph = SEG_4;
      4'd5:      glyph = SEG_5;
      4'd6:      glyph = SEG_6;
      4'd7:      glyph = SEG_7;
      4'd8:      glyph = SEG_8;
      4'd9:      glyph = SEG_9;
      BCD_MINUS: glyph = SEG_MINUS;
      default:   glyph = SEG_BLANK;
    endcase
  end

  assign seg = glyph | {dp, 7'b0};

endmodule

// File: rtl/display_serializer.sv
// display_serializer -- decodes NUM_DIGITS BCD digits (+ decimal points) and
// shifts the frame out to an external shift-register display chain, then
// strobes latch and reports completion with a one-cycle done pulse.
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-low reset
//   enable    in   gates acceptance of start
//   start     in   frame request, only honoured in IDLE
//   bcd_in    in   packed digits, digit k at [4k+3:4k], digit 0 rightmost
//   dp_in     in   decimal point per digit
//   ser_clk   out  bit clock: CLK_DIV cycles low, then CLK_DIV cycles high
//   ser_data  out  serial data, changes only when ser_clk falls
//   latch     out  high for CLK_DIV cycles after the last bit
//   busy      out  high while a frame is in progress
//   done      out  one-cycle pulse at frame completion
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero blanking).
module display_serializer
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_BITS   = 8,
  parameter int CLK_DIV    = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    ser_clk,
  output logic                    ser_data,
  output logic                    latch,
  output logic                    busy,
  output logic                    done
);

  localparam int FRAME_BITS = NUM_DIGITS * SEG_BITS;
  localparam int DIV_W      = $clog2(CLK_DIV) + 1;
  localparam int BIT_W      = $clog2(FRAME_BITS) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  // ---------------------------------------------------------------- decode
  logic [SEG_BITS-1:0]   seg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;
  logic [FRAME_BITS-1:0] frame;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_to_7seg u_dec (
      .bcd (bcd_in[4*k +: 4]),
      .dp  (dp_in[k]),
      .seg (seg[k])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the most significant digit; blanking stops at the first
  // nonzero code (minus included) or set dp. Digit 0 always shows.
  always_comb begin
    logic leading;
    leading = 1'b1;
    blank   = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (leading && bcd_in[4*k +: 4] == 4'd0 && !dp_in[k]) blank[k] = 1'b1;
      else                                                   leading  = 1'b0;
    end
  end
`else
  assign blank = '0;
`endif

  // Frame is laid out so that its MSB is the first bit on the wire: the top
  // digit occupies the top byte, and each byte is bit-reversed for LSB-first.
  always_comb begin
    frame = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      for (int j = 0; j < SEG_BITS; j++) begin
        frame[k*SEG_BITS + j] = blank[k] ? 1'b0 :
                                (MSB_FIRST != 0) ? seg[k][j] : seg[k][SEG_BITS-1-j];
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t                state, state_n;
  logic [DIV_W-1:0]      div_cnt, div_n;
  logic [BIT_W-1:0]      bit_cnt, bit_n;
  logic                  sclk_n, sdata_n;
  logic                  load, shift;
  logic [FRAME_BITS-1:0] shreg;

  // NOTE: every output of this block is assigned a default before the case,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    sclk_n  = ser_clk;
    sdata_n = ser_data;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && enable) begin
          state_n = S_SHIFT;
          div_n   = '0;
          bit_n   = '0;
          sclk_n  = 1'b0;
          sdata_n = frame[FRAME_BITS-1];
          load    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_n = div_cnt + 1'b1;
        end else begin
          div_n = '0;
          if (!ser_clk) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state_n = S_LATCH;
            end else begin
              bit_n   = bit_cnt + 1'b1;
              sdata_n = shreg[FRAME_BITS-1];
              shift   = 1'b1;
            end
          end
        end
      end
      S_LATCH: begin
        if (div_cnt != DIV_LAST) begin
          div_n = div_cnt + 1'b1;
        end else begin
          div_n   = '0;
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      ser_clk  <= 1'b0;
      ser_data <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      bit_cnt  <= bit_n;
      ser_clk  <= sclk_n;
      ser_data <= sdata_n;
    end
  end

  // NOTE: the shift register is pure datapath and is always loaded before
  // use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load)       shreg <= {frame[FRAME_BITS-2:0], 1'b0};
    else if (shift) shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
  end

  assign busy  = (state == S_SHIFT) || (state == S_LATCH);
  assign latch = (state == S_LATCH);
  assign done  = (state == S_DONE);

endmodule
